// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 access codes, LSU state encoding
// and the access legality check used when a request is accepted.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

  // Illegal funct3 for the direction, or an access not aligned to its size.
  function automatic logic lsu_access_err(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
    logic legal;
    logic misal;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    misal = (((f3 == F3_H) || (f3 == F3_HU)) && a[0]) ||
            ((f3 == F3_W) && (a != 2'b00));
    return ~legal | misal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the LSU: extracts and extends load data from a memory word,
// and merges sub-word store data into a previously read word.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  assign w_half = i_word[{i_addr[1], 4'b0000} +: 16];

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_H:    o_load = {{(XLEN-16){w_half[15]}}, w_half};
      F3_BU:   o_load = {{(XLEN-8){1'b0}}, w_byte};
      F3_HU:   o_load = {{(XLEN-16){1'b0}}, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_store = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_store = i_word;
        o_store[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
      end
      F3_H: begin
        o_store = i_word;
        o_store[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns byte-addressed RISC-V loads/stores into word
// accesses on a whole-word-write data memory, with RMW for SB/SH.
//
// state | meaning
// IDLE  | ready; accept, latch and legality-check a request
// READ  | capture mem_rd (load result or RMW base word)
// WRITE | one-cycle mem_we with the final word
// RESP  | one-cycle resp_valid
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_word;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_err;
  logic [XLEN-1:0] w_align_word;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_store;

  assign w_accept = req_valid && (r_state == LSU_IDLE);
  assign w_err    = lsu_access_err(req_we, req_funct3, req_addr[1:0]);

  // Loads extract straight from memory in READ; stores merge into the captured word.
  assign w_align_word = (r_state == LSU_READ) ? mem_rd : r_word;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3 (r_funct3),
    .i_addr   (r_addr[1:0]),
    .i_word   (w_align_word),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          if (w_err)                                  w_next = LSU_RESP;
          else if (req_we && (req_funct3 == F3_W))    w_next = LSU_WRITE;
          else                                        w_next = LSU_READ;
        end
      end
      LSU_READ:  w_next = r_we ? LSU_WRITE : LSU_RESP;
      LSU_WRITE: w_next = LSU_RESP;
      LSU_RESP:  w_next = LSU_IDLE;
      default:   w_next = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == LSU_IDLE);
    resp_valid = (r_state == LSU_RESP) && !rst;
    mem_we     = (r_state == LSU_WRITE) && !rst;
    mem_wd     = (r_state == LSU_WRITE) ? w_store : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_err) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        LSU_READ: begin
          r_word <= mem_rd;
          if (!r_we) begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
          end
        end
        LSU_WRITE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = {2'b00, r_addr[XLEN-1:2]};
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
